// File: rtl/music_sequencer.sv
// music_sequencer
//   Steps the song ROM address at a fixed tempo, latches the note number the
//   ROM returns and turns it into a square-wave buzzer drive.
//
//   Each song step is STEP_CYCLES clocks: FETCH (1) -> LATCH (1) -> PLAY
//   (STEP_CYCLES-2). The tone generator keeps running on the previously
//   latched note while the next one is being fetched.
//
// Parameters
//   STEP_CYCLES  clocks per song step (>= 4)
//   LAST_ADDR    final ROM address of the song
//   DIV_SHIFT    extra right-shift applied to every half-period
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   start    in   pulse, begins playback at address 0 (ignored while playing)
//   stop     in   pulse, aborts playback (wins over start)
//   loop_en  in   wrap LAST_ADDR -> 0 instead of finishing
//   address  out  song ROM address
//   note     in   ROM data, valid one clock after address is sampled
//   audio    out  square-wave buzzer drive
//   playing  out  high from start accept until back in idle
//
// Build option
//   MUSIC_SEQ_GAP_EN  when defined, audio is silenced for the final
//                     STEP_CYCLES/8 clocks of every PLAY so repeated notes are
//                     articulated; the phase counter keeps running underneath.
module music_sequencer #(
  parameter int unsigned STEP_CYCLES = 12_500_000,
  parameter logic [7:0]  LAST_ADDR   = 8'd242,
  parameter int unsigned DIV_SHIFT   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic [7:0] address,
  input  logic [7:0] note,
  output logic       audio,
  output logic       playing
);

  localparam int unsigned        STEP_W    = $clog2(STEP_CYCLES);
  localparam logic [STEP_W-1:0]  PLAY_LAST = STEP_W'(STEP_CYCLES - 3);
`ifdef MUSIC_SEQ_GAP_EN
  localparam logic [STEP_W-1:0]  GAP_FIRST = STEP_W'(STEP_CYCLES - 2 - STEP_CYCLES / 8);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_PLAY
  } state_t;

  state_t              state_q,    state_d;
  logic [7:0]          address_q,  address_d;
  logic [7:0]          cur_note_q, cur_note_d;
  logic [STEP_W-1:0]   step_q,     step_d;
  logic [19:0]         phase_q,    phase_d;
  logic                tone_q,     tone_d;
  logic                audio_q,    audio_d;
  logic                playing_q,  playing_d;

  logic [19:0]         hp_cur;
  logic                rest_cur;

  // Notes outside the playable range (including 0) are rests.
  function automatic logic note_is_rest(input logic [7:0] n);
    return (n < 8'd12) || (n > 8'd59);
  endfunction

  // Half-periods of the octave starting at note 24 (C4), in 100 MHz clocks.
  function automatic logic [19:0] base_half(input logic [3:0] s);
    case (s)
      4'd0:    return 20'd191113;
      4'd1:    return 20'd180386;
      4'd2:    return 20'd170262;
      4'd3:    return 20'd160706;
      4'd4:    return 20'd151686;
      4'd5:    return 20'd143173;
      4'd6:    return 20'd135137;
      4'd7:    return 20'd127553;
      4'd8:    return 20'd120393;
      4'd9:    return 20'd113636;
      4'd10:   return 20'd107258;
      default: return 20'd101239;
    endcase
  endfunction

  // Playable notes span octaves -1..+2 around note 24; one octave down
  // doubles the half-period, each octave up halves it. Result saturates to
  // the 20-bit counter range and never drops below 1.
  function automatic logic [19:0] half_period(input logic [7:0] n);
    logic [20:0] hp;
    if (n < 8'd24)      hp = {base_half(4'(n - 8'd12)), 1'b0};
    else if (n < 8'd36) hp = {1'b0, base_half(4'(n - 8'd24))};
    else if (n < 8'd48) hp = {1'b0, base_half(4'(n - 8'd36))} >> 1;
    else                hp = {1'b0, base_half(4'(n - 8'd48))} >> 2;
    hp = hp >> DIV_SHIFT;
    if (hp == 21'd0) return 20'd1;
    if (hp[20])      return 20'hFFFFF;
    return hp[19:0];
  endfunction

  assign hp_cur   = half_period(cur_note_q);
  assign rest_cur = note_is_rest(cur_note_q);

  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    cur_note_d = cur_note_q;
    step_d     = step_q;
    playing_d  = playing_q;
    phase_d    = phase_q;
    tone_d     = tone_q;

    // Tone generator free-runs on the latched note in every active state.
    if (rest_cur) begin
      phase_d = 20'd0;
      tone_d  = 1'b0;
    end else if (phase_q == hp_cur - 20'd1) begin
      phase_d = 20'd0;
      tone_d  = ~tone_q;
    end else begin
      phase_d = phase_q + 20'd1;
    end

    case (state_q)
      ST_IDLE: begin
        phase_d = 20'd0;
        tone_d  = 1'b0;
        if (start && !stop) begin
          state_d   = ST_FETCH;
          address_d = 8'd0;
          playing_d = 1'b1;
        end
      end
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        state_d    = ST_PLAY;
        step_d     = '0;
        cur_note_d = note;
        // A repeated note keeps its phase (legato); a new note restarts it.
        if (note != cur_note_q) begin
          phase_d = 20'd0;
          tone_d  = 1'b0;
        end
      end
      ST_PLAY: begin
        if (step_q == PLAY_LAST) begin
          if (address_q == LAST_ADDR && !loop_en) begin
            state_d    = ST_IDLE;
            playing_d  = 1'b0;
            cur_note_d = 8'd0;
            phase_d    = 20'd0;
            tone_d     = 1'b0;
          end else begin
            state_d   = ST_FETCH;
            address_d = (address_q == LAST_ADDR) ? 8'd0 : address_q + 8'd1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (stop && state_q != ST_IDLE) begin
      state_d    = ST_IDLE;
      playing_d  = 1'b0;
      address_d  = 8'd0;
      cur_note_d = 8'd0;
      step_d     = '0;
      phase_d    = 20'd0;
      tone_d     = 1'b0;
    end

    audio_d = tone_d;
`ifdef MUSIC_SEQ_GAP_EN
    if (state_d == ST_PLAY && step_d >= GAP_FIRST) audio_d = 1'b0;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      address_q  <= 8'd0;
      cur_note_q <= 8'd0;
      step_q     <= '0;
      phase_q    <= 20'd0;
      tone_q     <= 1'b0;
      audio_q    <= 1'b0;
      playing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      cur_note_q <= cur_note_d;
      step_q     <= step_d;
      phase_q    <= phase_d;
      tone_q     <= tone_d;
      audio_q    <= audio_d;
      playing_q  <= playing_d;
    end
  end

  assign address = address_q;
  assign audio   = audio_q;
  assign playing = playing_q;

endmodule

// File: doc/music_sequencer.md
# music_sequencer

Drives the song ROM address at a fixed tempo, consumes the registered note number it returns, and synthesises a square-wave buzzer output. It sits directly upstream and downstream of the note ROM: `address` feeds the ROM, and the ROM's `note` comes back into this block. The block owns start/stop/loop control and exposes a `playing` flag to the game FSM.

## Interface
Parameters:
- STEP_CYCLES, 12_500_000, clocks per song step (125 ms at 100 MHz); must be ≥ 4.
- LAST_ADDR, 8'd242, final ROM address of the song.
- DIV_SHIFT, 0, right-shift applied to every half-period (simulation speed-up).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; begins playback at address 0.
- stop  in  1  pulse; aborts playback.
- loop_en  in  1  when 1, wraps LAST_ADDR → 0 instead of finishing.
- address  out  8  ROM address.
- note  in  8  ROM data, valid 1 clk after `address` is sampled.
- audio  out  1  square-wave buzzer drive.
- playing  out  1  high from the start accept until idle.

## Operation
- FSM states and transitions:
  - IDLE → FETCH on `start`.
  - FETCH (1 clk) → LATCH (1 clk) → PLAY (STEP_CYCLES−2 clks).
  - At the end of PLAY:
    - `address`==LAST_ADDR and !loop_en → IDLE.
    - Otherwise, `address` increments (LAST_ADDR wraps to 0) → FETCH.
- `address` updates on the edge entering FETCH. The ROM registers it at the FETCH→LATCH edge. LATCH samples `note` into `cur_note` on the LATCH→PLAY edge.
- Note decode:
  - `cur_note` 0, or outside 12..59 → rest: `audio`=0, phase counter held at 0.
  - Otherwise, s=(cur_note−24) mod 12 selects the base half-period, and o=floor((cur_note−24)/12) selects the octave.
  - Half-period = (base << −o if o<0, else base >> o) >> DIV_SHIFT, minimum 1.
- Base half-period table (100 MHz, note 24 = C4):
  - C 191113, C# 180386, D 170262, D# 160706.
  - E 151686, F 143173, F# 135137, G 127553.
  - G# 120393, A 113636, A# 107258, B 101239.
  - Counter width 20 bits.
- Tone: a phase counter counts to half-period−1, then `audio` toggles and the counter clears.
- Legato: if the newly latched note equals the previous `cur_note`, the phase counter and `audio` continue undisturbed. If it differs, both clear to 0 at the LATCH→PLAY edge.
- During FETCH and LATCH, `audio` keeps generating the previous note.

## Timing
- Reset values:
  - `address`=0, `audio`=0, `playing`=0.
  - `cur_note`=0, phase counter=0, FSM=IDLE.
- Each step is exactly STEP_CYCLES clocks, from FETCH entry to the next FETCH entry.
- `start` → `playing`=1 on the next edge. The first note is audible 3 clks after `start`.
- Entering IDLE at natural end: `playing`=0, `audio`=0 on the same edge, and `address` holds LAST_ADDR.
- `stop` in any non-IDLE state: next edge goes to IDLE with `playing`=0, `audio`=0, `cur_note`=0, `address`=0.
- `start` and `stop` in the same cycle: `stop` wins.
- `start` while playing: ignored.
- `reset` mid-note: all state returns to reset values on that edge.

## Configuration
- MUSIC_SEQ_GAP_EN defined: `audio` is forced to 0 during the final STEP_CYCLES/8 clocks of every PLAY, so repeated notes are articulated. The phase counter keeps running, and legato still applies to the phase.
- MUSIC_SEQ_GAP_EN undefined: tone is continuous across steps.

## Test plan
- Test parameters: STEP_CYCLES=64, DIV_SHIFT=12, LAST_ADDR=3, ROM model returns 33,33,0,45.
- Start, no loop:
  - `address` sequence 0,1,2,3, with FETCH entries 64 clks apart.
  - `audio` toggles every 27 clks during steps 0–1.
  - `audio` stays 0 during step 2.
  - Step 3 half-period is 13 (113636>>1>>12).
  - After step 3, `playing`=0.
- Legato: steps 0→1 both note 33 → no phase reset across the boundary; the toggle interval stays 27 clks straddling FETCH/LATCH.
- loop_en=1: after address 3, `address` returns to 0 and `playing` stays 1 through 3 full loops.
- `stop` mid-PLAY of step 1 → next edge `playing`=0, `audio`=0, `address`=0. A subsequent `start` restarts at address 0.
- `reset` during PLAY, including with `start`/`stop` asserted simultaneously → all outputs 0 and FSM idle.
- With MUSIC_SEQ_GAP_EN: `audio`=0 for the last 8 clks of every step.
